// File: rtl/pulse_start_scheduler.sv
// pulse_start_scheduler: tick-timed ap_ctrl_hs start sequencer with run and overrun counting
module pulse_start_scheduler #(
  parameter int PERIOD_WIDTH = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    tick_in,
  input  logic [PERIOD_WIDTH-1:0] cfg_period_in,
  input  logic [COUNT_WIDTH-1:0]  cfg_count_in,
  input  logic                    go_in,
  input  logic                    abort_in,
  output logic                    ap_start_out,
  input  logic                    ap_ready_in,
  input  logic                    ap_done_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [COUNT_WIDTH-1:0]  runs_out,
  output logic [COUNT_WIDTH-1:0]  overrun_out
);
  typedef enum logic [2:0] {IDLE, WAIT, START, BUSY, DRAIN} state_t;
  state_t state, state_d;
  logic [PERIOD_WIDTH-1:0] period, cnt, last;
  logic [COUNT_WIDTH-1:0] count, runs_inc;
  logic abort_pend, abort_pend_d, fire, run_done, overrun, last_run, done_d;
  assign last = (period == '0) ? '0 : period - 1'b1;
  assign fire = state != IDLE && tick_in && cnt == last;
  assign runs_inc = runs_out + 1'b1;
  assign last_run = count != '0 && runs_inc == count;
  // A completed run exits through the same rules whether accept and done coincide or not
  always_comb begin
    state_d = state;
    abort_pend_d = abort_pend;
    done_d = 1'b0;
    run_done = 1'b0;
    overrun = 1'b0;
    case (state)
      IDLE: begin
        state_d = go_in ? WAIT : IDLE;
        abort_pend_d = 1'b0;
      end
      WAIT: begin
        state_d = abort_in ? IDLE : fire ? START : WAIT;
        done_d = abort_in;
      end
      START: begin
        abort_pend_d = abort_pend | abort_in;
        if (ap_ready_in && ap_done_in) begin
          run_done = 1'b1;
          done_d = abort_pend_d || last_run;
          state_d = done_d ? IDLE : fire ? START : WAIT;
        end else begin
          overrun = fire;
          if (ap_ready_in) state_d = abort_pend_d ? DRAIN : BUSY;
        end
      end
      BUSY: begin
        if (ap_done_in) begin
          run_done = 1'b1;
          done_d = abort_in || last_run;
          state_d = done_d ? IDLE : fire ? START : WAIT;
        end else begin
          overrun = fire;
          if (abort_in) state_d = DRAIN;
        end
      end
      DRAIN: begin
        run_done = ap_done_in;
        done_d = ap_done_in;
        state_d = ap_done_in ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      period <= '0;
      count <= '0;
      cnt <= '0;
      abort_pend <= 1'b0;
      ap_start_out <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      runs_out <= '0;
      overrun_out <= '0;
    end else begin
      state <= state_d;
      abort_pend <= abort_pend_d;
      ap_start_out <= state_d == START;
      busy_out <= state_d != IDLE;
      done_out <= done_d;
      if (state == IDLE && go_in) begin
        period <= cfg_period_in;
        count <= cfg_count_in;
        cnt <= '0;
        runs_out <= '0;
        overrun_out <= '0;
      end else begin
        if (state != IDLE && tick_in) cnt <= fire ? '0 : cnt + 1'b1;
        if (run_done) runs_out <= runs_inc;
        if (overrun && overrun_out != '1) overrun_out <= overrun_out + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pulse_start_scheduler.sv
// tb_pulse_start_scheduler: scoreboard bench driving pulse_start_scheduler with a responding HLS core model
module tb_pulse_start_scheduler;
  logic clk = 0, rst_n = 0, tick = 0, go = 0, abort = 0, ap_ready = 0, ap_done = 0;
  logic [15:0] cfg_period = 0, cfg_count = 0;
  logic ap_start, busy, done;
  logic [15:0] runs, overrun;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int tick_per = 1, rdy_dly = 0, done_dly = 1;
  int rc = 0, dc = 0;
  bit cbusy = 0;
  typedef struct {int runs; int overrun; int starts;} res_t;
  res_t res_q[$];
  int gap_q[$], wid_q[$];
  int starts = 0, done_cnt = 0, done_base = 0, rise_cyc = 0;
  bit have_rise = 0, start_prev = 0, done_prev = 0, busy_prev = 0;

  pulse_start_scheduler dut (
    .clk_in(clk), .rst_n_in(rst_n), .tick_in(tick),
    .cfg_period_in(cfg_period), .cfg_count_in(cfg_count),
    .go_in(go), .abort_in(abort),
    .ap_start_out(ap_start), .ap_ready_in(ap_ready), .ap_done_in(ap_done),
    .busy_out(busy), .done_out(done), .runs_out(runs), .overrun_out(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) tick = tick_per > 0 && cyc % tick_per == 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // HLS core: accepts rdy_dly cycles after ap_start appears, completes done_dly cycles after accept
  always @(negedge clk) begin
    ap_ready = 0;
    ap_done = 0;
    if (!rst_n) begin
      cbusy = 0;
      rc = 0;
    end else if (cbusy) begin
      if (dc == 0) begin
        ap_done = 1;
        cbusy = 0;
      end else dc--;
    end else if (ap_start) begin
      if (rc == rdy_dly) begin
        ap_ready = 1;
        rc = 0;
        if (done_dly == 0) ap_done = 1;
        else begin
          cbusy = 1;
          dc = done_dly - 1;
        end
      end else rc++;
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (busy && !busy_prev) begin
      starts = 0;
      have_rise = 0;
    end
    if (ap_start && !start_prev) begin
      starts++;
      if (have_rise && gap_q.size() > 0) check("start_gap", cyc - rise_cyc, gap_q.pop_front());
      have_rise = 1;
      rise_cyc = cyc;
    end
    if (!ap_start && start_prev && wid_q.size() > 0) check("start_width", cyc - rise_cyc, wid_q.pop_front());
    if (done) begin
      done_cnt++;
      check("done_width", done_prev, 0);
      check("busy_at_done", busy, 0);
      if (res_q.size() > 0) begin
        r = res_q.pop_front();
        check("runs", runs, r.runs);
        check("overrun", overrun, r.overrun);
        check("starts", starts, r.starts);
      end else check("done_unexpected", done, 0);
    end
    start_prev = ap_start;
    done_prev = done;
    busy_prev = busy;
  end

  task automatic expect_res(input int r, input int o, input int s);
    res_t e;
    e.runs = r;
    e.overrun = o;
    e.starts = s;
    res_q.push_back(e);
  endtask

  task automatic run_seq(input int per, input int cnt, input int tp, input int rd, input int dd);
    @(negedge clk);
    cfg_period = 16'(per);
    cfg_count = 16'(cnt);
    tick_per = tp;
    rdy_dly = rd;
    done_dly = dd;
    done_base = done_cnt;
    go = 1;
    @(negedge clk);
    go = 0;
    check("busy_after_go", busy, 1);
    check("runs_cleared", runs, 0);
    check("overrun_cleared", overrun, 0);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done_cnt == done_base && k < bound) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("done_pulses", done_cnt - done_base, 1);
  endtask

  task automatic queues_empty(input string tag);
    check({tag, "_res_left"}, res_q.size(), 0);
    check({tag, "_gap_left"}, gap_q.size(), 0);
    check({tag, "_wid_left"}, wid_q.size(), 0);
    res_q.delete();
    gap_q.delete();
    wid_q.delete();
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_ap_start", ap_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_runs", runs, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1;
    // three runs, one start every 8 clocks
    expect_res(3, 0, 3);
    gap_q = '{8, 8};
    wid_q = '{1, 1, 1};
    run_seq(4, 3, 2, 0, 1);
    wait_done(200);
    queues_empty("s1");
    // slow core at one fire per cycle: two dropped fires per run
    expect_res(5, 10, 5);
    run_seq(1, 5, 1, 0, 2);
    wait_done(200);
    queues_empty("s2");
    // abort while start is pending on a late ready
    expect_res(1, 1, 1);
    wid_q = '{7};
    run_seq(4, 0, 1, 6, 1);
    k = 0;
    while (!ap_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("s3_start_seen", ap_start, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    wait_done(100);
    queues_empty("s3");
    // continuous mode, abort in WAIT coincident with a fire
    expect_res(4, 0, 4);
    gap_q = '{2, 2, 2};
    wid_q = '{1, 1, 1, 1};
    run_seq(0, 0, 2, 0, 0);
    k = 0;
    while (!(starts == 4 && !ap_start) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("s4_fourth_start", starts, 4);
    abort = 1;
    @(negedge clk);
    abort = 0;
    wait_done(20);
    repeat (10) @(negedge clk);
    check("s4_no_start_after_abort", starts, 4);
    queues_empty("s4");
    // done and fire in the same BUSY cycle go straight back to START
    expect_res(2, 0, 2);
    gap_q = '{2};
    wid_q = '{1, 1};
    run_seq(2, 2, 1, 0, 1);
    wait_done(100);
    queues_empty("s5");
    // reset in BUSY
    run_seq(2, 3, 1, 0, 5);
    k = 0;
    while (!(starts == 1 && !ap_start) && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("s6_busy_before_rst", busy, 1);
    check("s6_overrun_before_rst", overrun, 1);
    rst_n = 0;
    #1;
    check("s6_rst_ap_start", ap_start, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_done", done, 0);
    check("s6_rst_runs", runs, 0);
    check("s6_rst_overrun", overrun, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    expect_res(1, 0, 1);
    run_seq(3, 1, 1, 0, 1);
    wait_done(100);
    queues_empty("s6");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
